// File: rtl/gmm_score_engine.sv
// Diagonal-Gaussian mixture scorer: streams one HMM state's model from byte ROM,
// scores every mixture against the frame's features and reports the best one.
module gmm_score_engine #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int DIM_W    = 7,
    parameter int MIX_W    = 4,
    parameter int SQ_SHIFT = 4,
    parameter int ROM_AW   = 20,
    parameter int CEP_AW   = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROM_AW-1:0] base_addr,
    input  logic [CEP_AW-1:0] cep_base,
    input  logic [DIM_W-1:0]  dim_num,
    input  logic [MIX_W-1:0]  mix_num,
    output logic [ROM_AW-1:0] rom_address,
    input  logic [7:0]        rom_datain,
    output logic [CEP_AW-1:0] regcep_addr,
    input  logic [DATA_W-1:0] regcep_out,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  score,
    output logic [MIX_W-1:0]  best_mix,
    output logic              overflow,
    output logic [2:0]        dbg_state
);

    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = $clog2(BPW + 1);
    localparam int SQ_W  = 2 * DATA_W + 2;
    localparam int EXT_W = ((ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W) + 2;
    localparam logic signed [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN_EXT = EXT_W'(ACC_MIN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GCONST = 3'd1,
        S_MEAN   = 3'd2,
        S_PREC   = 3'd3,
        S_ACC    = 3'd4,
        S_CMP    = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ROM_AW-1:0]         rom_addr_q, rom_addr_d;
    logic [CEP_AW-1:0]         cep_addr_q, cep_addr_d;
    logic [CEP_AW-1:0]         cep_base_q, cep_base_d;
    logic [DIM_W-1:0]          dim_num_q, dim_num_d;
    logic [DIM_W-1:0]          dim_idx_q, dim_idx_d;
    logic [MIX_W-1:0]          mix_num_q, mix_num_d;
    logic [MIX_W-1:0]          mix_idx_q, mix_idx_d;
    logic [MIX_W-1:0]          best_idx_q, best_idx_d;
    logic [MIX_W-1:0]          best_mix_q, best_mix_d;
    logic [DATA_W-1:0]         shreg_q, shreg_d;
    logic [DATA_W-1:0]         mean_q, mean_d;
    logic [DATA_W-1:0]         feat_q, feat_d;
    logic [DATA_W-1:0]         prec_q, prec_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   best_q, best_d;
    logic signed [ACC_W-1:0]   score_q, score_d;
    logic                      overflow_q, overflow_d;

    logic [DATA_W-1:0]         word_w;
    logic                      fetch_last;
    logic signed [DATA_W:0]    diff_w;
    logic signed [SQ_W-1:0]    diff_ext_w;
    logic signed [SQ_W-1:0]    sq_full_w;
    logic signed [SQ_W-1:0]    sq_shift_w;
    logic [DATA_W-1:0]         sq_w;
    logic [2*DATA_W-1:0]       term_w;
    logic signed [EXT_W-1:0]   acc_ext_w;
    logic                      sat_w;
    logic signed [ACC_W-1:0]   acc_next_w;
    logic                      take_w;

    // Score datapath: subtraction is done wide so saturation is detected exactly.
    always_comb begin
        word_w     = (shreg_q << 8) | DATA_W'(rom_datain);
        diff_w     = $signed({feat_q[DATA_W-1], feat_q}) - $signed({mean_q[DATA_W-1], mean_q});
        diff_ext_w = SQ_W'(diff_w);
        sq_full_w  = diff_ext_w * diff_ext_w;
        sq_shift_w = sq_full_w >>> SQ_SHIFT;
        sq_w       = (|sq_shift_w[SQ_W-1:DATA_W]) ? '1 : sq_shift_w[DATA_W-1:0];
        term_w     = (2*DATA_W)'(sq_w) * (2*DATA_W)'(prec_q);
        acc_ext_w  = EXT_W'(acc_q) - $signed(EXT_W'(term_w));
        sat_w      = (acc_ext_w < ACC_MIN_EXT);
        acc_next_w = sat_w ? ACC_MIN : acc_ext_w[ACC_W-1:0];
        take_w     = (mix_idx_q == '0) || (acc_q > best_q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        cep_addr_d = cep_addr_q;
        cep_base_d = cep_base_q;
        dim_num_d  = dim_num_q;
        dim_idx_d  = dim_idx_q;
        mix_num_d  = mix_num_q;
        mix_idx_d  = mix_idx_q;
        best_idx_d = best_idx_q;
        best_mix_d = best_mix_q;
        shreg_d    = shreg_q;
        mean_d     = mean_q;
        feat_d     = feat_q;
        prec_d     = prec_q;
        acc_d      = acc_q;
        best_d     = best_q;
        score_d    = score_q;
        overflow_d = overflow_q;
        fetch_last = (cnt_q == CNT_W'(BPW));

        // Byte fetch: address issued on cycles 0..BPW-1, byte lands one cycle later.
        if (state_q == S_GCONST || state_q == S_MEAN || state_q == S_PREC) begin
            if (fetch_last) begin
                cnt_d = '0;
            end else begin
                cnt_d      = cnt_q + CNT_W'(1);
                rom_addr_d = rom_addr_q + ROM_AW'(1);
            end
            if (cnt_q != '0) shreg_d = word_w;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rom_addr_d = base_addr;
                    cep_base_d = cep_base;
                    dim_num_d  = dim_num;
                    mix_num_d  = mix_num;
                    mix_idx_d  = '0;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                    if (mix_num == '0) begin
                        score_d    = ACC_MIN;
                        best_mix_d = '0;
                        state_d    = S_FIN;
                    end else begin
                        state_d = S_GCONST;
                    end
                end
            end
            S_GCONST: begin
                if (fetch_last) begin
                    acc_d = ACC_W'($signed(word_w));
                    if (dim_num_q == '0) begin
                        state_d = S_CMP;
                    end else begin
                        dim_idx_d  = '0;
                        cep_addr_d = cep_base_q;
                        state_d    = S_MEAN;
                    end
                end
            end
            S_MEAN: begin
                if (fetch_last) begin
                    mean_d  = word_w;
                    feat_d  = regcep_out;
                    state_d = S_PREC;
                end
            end
            S_PREC: begin
                if (fetch_last) begin
                    prec_d  = word_w;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = acc_next_w;
                if (sat_w) overflow_d = 1'b1;
                if (dim_idx_q == dim_num_q - DIM_W'(1)) begin
                    state_d = S_CMP;
                end else begin
                    dim_idx_d  = dim_idx_q + DIM_W'(1);
                    cep_addr_d = cep_addr_q + CEP_AW'(1);
                    state_d    = S_MEAN;
                end
            end
            S_CMP: begin
                if (take_w) begin
                    best_d     = acc_q;
                    best_idx_d = mix_idx_q;
                end
                if (mix_idx_q == mix_num_q - MIX_W'(1)) begin
                    score_d    = take_w ? acc_q : best_q;
                    best_mix_d = take_w ? mix_idx_q : best_idx_q;
                    state_d    = S_FIN;
                end else begin
                    mix_idx_d = mix_idx_q + MIX_W'(1);
                    state_d   = S_GCONST;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            cep_addr_q <= '0;
            cep_base_q <= '0;
            dim_num_q  <= '0;
            dim_idx_q  <= '0;
            mix_num_q  <= '0;
            mix_idx_q  <= '0;
            best_idx_q <= '0;
            best_mix_q <= '0;
            shreg_q    <= '0;
            mean_q     <= '0;
            feat_q     <= '0;
            prec_q     <= '0;
            acc_q      <= '0;
            best_q     <= '0;
            score_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            cep_addr_q <= cep_addr_d;
            cep_base_q <= cep_base_d;
            dim_num_q  <= dim_num_d;
            dim_idx_q  <= dim_idx_d;
            mix_num_q  <= mix_num_d;
            mix_idx_q  <= mix_idx_d;
            best_idx_q <= best_idx_d;
            best_mix_q <= best_mix_d;
            shreg_q    <= shreg_d;
            mean_q     <= mean_d;
            feat_q     <= feat_d;
            prec_q     <= prec_d;
            acc_q      <= acc_d;
            best_q     <= best_d;
            score_q    <= score_d;
            overflow_q <= overflow_d;
        end
    end

    assign rom_address = rom_addr_q;
    assign regcep_addr = cep_addr_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done        = (state_q == S_FIN);
    assign score       = score_q;
    assign best_mix    = best_mix_q;
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_gmm_score_engine.sv
// Directed bench for gmm_score_engine: a 16-bit default instance and a 24/40-bit
// instance whose model block straddles the top of the ROM address space.
module tb_gmm_score_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_a;
    logic [19:0] base_a;
    logic [12:0] cep_base_a;
    logic [6:0]  dim_a;
    logic [3:0]  mix_a;
    logic [19:0] rom_addr_a;
    logic [7:0]  rom_data_a;
    logic [12:0] cep_addr_a;
    logic [15:0] cep_data_a;
    logic        busy_a, done_a, ovf_a;
    logic [31:0] score_a;
    logic [3:0]  best_a;
    logic [2:0]  dbg_a;

    logic        start_b;
    logic [19:0] base_b;
    logic [12:0] cep_base_b;
    logic [6:0]  dim_b;
    logic [3:0]  mix_b;
    logic [19:0] rom_addr_b;
    logic [7:0]  rom_data_b;
    logic [12:0] cep_addr_b;
    logic [23:0] cep_data_b;
    logic        busy_b, done_b, ovf_b;
    logic [39:0] score_b;
    logic [3:0]  best_b;
    logic [2:0]  dbg_b;

    logic [7:0]  rom_a [0:4095];
    logic [15:0] cep_a [0:8191];
    logic [7:0]  rom_b [0:4095];
    logic [23:0] cep_b [0:8191];

    int checks = 0;
    int errors = 0;

    gmm_score_engine u_a (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a),
        .cep_base(cep_base_a), .dim_num(dim_a), .mix_num(mix_a),
        .rom_address(rom_addr_a), .rom_datain(rom_data_a),
        .regcep_addr(cep_addr_a), .regcep_out(cep_data_a),
        .busy(busy_a), .done(done_a), .score(score_a), .best_mix(best_a),
        .overflow(ovf_a), .dbg_state(dbg_a)
    );

    gmm_score_engine #(.DATA_W(24), .ACC_W(40)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b),
        .cep_base(cep_base_b), .dim_num(dim_b), .mix_num(mix_b),
        .rom_address(rom_addr_b), .rom_datain(rom_data_b),
        .regcep_addr(cep_addr_b), .regcep_out(cep_data_b),
        .busy(busy_b), .done(done_b), .score(score_b), .best_mix(best_b),
        .overflow(ovf_b), .dbg_state(dbg_b)
    );

    // Synchronous memories: data valid the cycle after the address.
    always @(posedge clk) begin
        rom_data_a <= rom_a[rom_addr_a[11:0]];
        cep_data_a <= cep_a[cep_addr_a];
        rom_data_b <= rom_b[rom_addr_b[11:0]];
        cep_data_b <= cep_b[cep_addr_b];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_a(input logic [19:0] addr, input logic [15:0] w);
        logic [19:0] a1;
        a1 = addr + 20'd1;
        rom_a[addr[11:0]] = w[15:8];
        rom_a[a1[11:0]]   = w[7:0];
    endtask

    task automatic put_b(input logic [19:0] addr, input logic [23:0] w);
        logic [19:0] a1, a2;
        a1 = addr + 20'd1;
        a2 = addr + 20'd2;
        rom_b[addr[11:0]] = w[23:16];
        rom_b[a1[11:0]]   = w[15:8];
        rom_b[a2[11:0]]   = w[7:0];
    endtask

    task automatic run_a(input logic [19:0] ba, input logic [12:0] cb, input logic [6:0] dn,
                         input logic [3:0] mn, output int lat);
        @(negedge clk);
        base_a = ba; cep_base_a = cb; dim_a = dn; mix_a = mn; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        lat = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            lat++;
            if (done_a === 1'b1) break;
        end
    endtask

    task automatic run_b(input logic [19:0] ba, input logic [12:0] cb, input logic [6:0] dn,
                         input logic [3:0] mn, output int lat, output logic [19:0] addr3);
        @(negedge clk);
        base_b = ba; cep_base_b = cb; dim_b = dn; mix_b = mn; start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        lat = 0;
        addr3 = '1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 3) addr3 = rom_addr_b;
            if (done_b === 1'b1) break;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [19:0] addr3;
        reset = 1'b1;
        start_a = 1'b0; base_a = '0; cep_base_a = '0; dim_a = '0; mix_a = '0;
        start_b = 1'b0; base_b = '0; cep_base_b = '0; dim_b = '0; mix_b = '0;
        for (int i = 0; i < 4096; i++) begin rom_a[i] = '0; rom_b[i] = '0; end
        for (int i = 0; i < 8192; i++) begin cep_a[i] = '0; cep_b[i] = '0; end

        // Default model: two mixtures, one dimension.
        put_a(20'h100, 16'd100); put_a(20'h102, 16'h0008); put_a(20'h104, 16'd3);
        put_a(20'h106, 16'd50);  put_a(20'h108, 16'h0010); put_a(20'h10A, 16'd0);
        cep_a[13'h20] = 16'h0010;
        // Tie and three-mixture models, no dimensions.
        put_a(20'h200, 16'hFFEC); put_a(20'h202, 16'hFFEC);
        put_a(20'h210, 16'd5); put_a(20'h212, 16'd30); put_a(20'h214, 16'd30);
        // Saturating model.
        put_a(20'h300, 16'h0000); put_a(20'h302, 16'h8000); put_a(20'h304, 16'hFFFF);
        cep_a[13'h40] = 16'h7FFF;
        // Four-dimension model.
        put_a(20'h400, 16'd1000);
        put_a(20'h402, 16'h0008); put_a(20'h404, 16'd3);
        put_a(20'h406, 16'h0020); put_a(20'h408, 16'd2);
        put_a(20'h40A, 16'h0004); put_a(20'h40C, 16'd5);
        put_a(20'h40E, 16'h0000); put_a(20'h410, 16'd1);
        cep_a[13'h60] = 16'h0010; cep_a[13'h61] = 16'h0000;
        cep_a[13'h62] = 16'hFFFC; cep_a[13'h63] = 16'h0100;
        // Wide model straddling the ROM and cepstrum address tops.
        put_b(20'hFFFFE, 24'h100000); put_b(20'h00001, 24'hFFFF00); put_b(20'h00004, 24'h001000);
        put_b(20'h00007, 24'h7FFFFF); put_b(20'h0000A, 24'h000064);
        put_b(20'h0000D, 24'hFFFFF0); put_b(20'h00010, 24'h000100); put_b(20'h00013, 24'hFFFFFF);
        put_b(20'h00016, 24'h7FFFF0); put_b(20'h00019, 24'h000005);
        cep_b[13'h1FFF] = 24'h000100; cep_b[13'h0000] = 24'h7FFFF0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_score", 64'(score_a), 64'd0);
        chk("rst_best", 64'(best_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_rom", 64'(rom_addr_a), 64'd0);
        chk("rst_cep", 64'(cep_addr_a), 64'd0);
        chk("rst_b_busy", 64'(busy_b), 64'd0);
        chk("rst_b_state", 64'(dbg_b), 64'd0);
        reset = 1'b0;

        run_a(20'h100, 13'h20, 7'd1, 4'd2, lat);
        chk("def_lat", 64'(lat), 64'd23);
        chk("def_score", 64'(score_a), 64'd88);
        chk("def_best", 64'(best_a), 64'd0);
        chk("def_ovf", 64'(ovf_a), 64'd0);
        @(negedge clk);
        chk("def_done_pulse", 64'(done_a), 64'd0);
        chk("def_busy_after", 64'(busy_a), 64'd0);

        run_a(20'h200, 13'h0, 7'd0, 4'd2, lat);
        chk("tie_lat", 64'(lat), 64'd9);
        chk("tie_score", 64'(score_a), 64'hFFFF_FFEC);
        chk("tie_best", 64'(best_a), 64'd0);

        run_a(20'h210, 13'h0, 7'd0, 4'd3, lat);
        chk("mix3_lat", 64'(lat), 64'd13);
        chk("mix3_score", 64'(score_a), 64'd30);
        chk("mix3_best", 64'(best_a), 64'd1);

        run_a(20'h300, 13'h40, 7'd1, 4'd1, lat);
        chk("sat_lat", 64'(lat), 64'd12);
        chk("sat_score", 64'(score_a), 64'h8000_0000);
        chk("sat_ovf", 64'(ovf_a), 64'd1);

        run_a(20'h100, 13'h20, 7'd1, 4'd2, lat);
        chk("benign_ovf", 64'(ovf_a), 64'd0);
        chk("benign_score", 64'(score_a), 64'd88);

        run_a(20'h100, 13'h20, 7'd1, 4'd0, lat);
        chk("mix0_lat", 64'(lat), 64'd1);
        chk("mix0_score", 64'(score_a), 64'h8000_0000);
        chk("mix0_best", 64'(best_a), 64'd0);

        // start pulsed mid-job must not restart it.
        @(negedge clk);
        base_a = 20'h100; cep_base_a = 13'h20; dim_a = 7'd1; mix_a = 4'd2; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        lat = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                chk("busy_mid", 64'(busy_a), 64'd1);
                start_a = 1'b1; mix_a = 4'd0;
            end else begin
                start_a = 1'b0;
            end
            if (done_a === 1'b1) break;
        end
        chk("busy_ign_lat", 64'(lat), 64'd23);
        chk("busy_ign_score", 64'(score_a), 64'd88);
        // start held through the done cycle: ignored then, accepted one cycle later.
        start_a = 1'b1; mix_a = 4'd0;
        @(negedge clk);
        chk("done_ign_done", 64'(done_a), 64'd0);
        chk("done_ign_busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        start_a = 1'b0;
        chk("after_done_acc", 64'(done_a), 64'd1);
        chk("after_done_score", 64'(score_a), 64'h8000_0000);

        // Reset during the precision fetch of dimension 3.
        @(negedge clk);
        base_a = 20'h400; cep_base_a = 13'h60; dim_a = 7'd4; mix_a = 4'd1; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        for (int i = 0; i < 29; i++) @(negedge clk);
        chk("rstmid_state", 64'(dbg_a), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", 64'(busy_a), 64'd0);
        chk("rstmid_done", 64'(done_a), 64'd0);
        chk("rstmid_score", 64'(score_a), 64'd0);
        chk("rstmid_best", 64'(best_a), 64'd0);
        chk("rstmid_ovf", 64'(ovf_a), 64'd0);
        chk("rstmid_rom", 64'(rom_addr_a), 64'd0);
        chk("rstmid_cep", 64'(cep_addr_a), 64'd0);
        run_a(20'h400, 13'h60, 7'd4, 4'd1, lat);
        chk("dim4_lat", 64'(lat), 64'd33);
        chk("dim4_score", 64'(score_a), 64'hFFFF_F348);
        chk("dim4_best", 64'(best_a), 64'd0);
        chk("dim4_ovf", 64'(ovf_a), 64'd0);

        run_b(20'hFFFFE, 13'h1FFF, 7'd2, 4'd2, lat, addr3);
        chk("wide_wrap_addr", 64'(addr3), 64'h0);
        chk("wide_lat", 64'(lat), 64'd47);
        chk("wide_score", 64'(score_b), 64'hFF_FFFF_FFF0);
        chk("wide_best", 64'(best_b), 64'd1);
        chk("wide_ovf", 64'(ovf_b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
